ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Receives raw PS/2 keyboard clock/data, deserializes 11-bit device->host frames and
//  folds E0 (extended) / F0 (break) prefixes into one key event. Produces the 11-bit
//  ps2_key word consumed by the emu input decoder: [10] toggle, [9] pressed,
//  [8] extended, [7:0] scancode. Used when a core takes a physical keyboard on USER_IN.
// PARAMETERS
//  FILTER_LEN  8      clk_sys cycles a synced PS/2 line must hold before a level change is accepted
//  TIMEOUT     12000  clk_sys cycles with no filtered clock fall mid-frame before abort (1 ms @ 12 MHz)
// PORTS
//  clk_sys    in   1   system clock; single clock domain
//  reset      in   1   synchronous, active-high reset
//  ps2_clk    in   1   raw PS/2 clock line, asynchronous
//  ps2_data   in   1   raw PS/2 data line, asynchronous
//  ps2_key    out  11  {toggle, pressed, extended, code[7:0]}
//  frame_err  out  1   one-cycle pulse: parity error, bad start/stop, or timeout
//  busy       out  1   1 while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset: ps2_key=0, frame_err=0, busy=0, state=IDLE, ext/rel flags=0, skip=0,
//   filters forced to 1. Reset mid-frame discards the partial frame; no event emitted.
//  Input path: 2-flop synchronizer per line. Counter filter: output level changes only
//   after FILTER_LEN consecutive cycles at the new level. fall = filtered clk 1->0.
//   All data sampling uses filtered data on the cycle fall is asserted.
//  FSM states IDLE, DATA, PARITY, STOP:
//   IDLE:   on fall with data=0 -> DATA, bit_cnt=0. On fall with data=1 -> frame_err, stay IDLE.
//   DATA:   on fall shift data into sr LSB-first (sr <= {d, sr[7:1]}), bit_cnt++. After 8th bit -> PARITY.
//   PARITY: on fall latch p. -> STOP.
//   STOP:   on fall: if data==1 and ^{sr,p}==1 (odd parity) -> byte_ok; else frame_err. -> IDLE.
//   Timeout: in DATA/PARITY/STOP, idle counter resets on each fall; reaching TIMEOUT -> frame_err, IDLE.
//   Counter width = $clog2(TIMEOUT+1); it saturates and never wraps.
//  Byte handler (on byte_ok, same cycle the STOP fall is seen; ps2_key registered, valid next cycle):
//   skip!=0    : skip--, no other action (E1 Pause sequence swallowed).
//   sr==8'hE1  : skip<=7, ext/rel cleared, no event.
//   sr==8'hE0  : ext<=1, no event.      sr==8'hF0 : rel<=1, no event.
//   sr==8'hAA/8'hFA/8'hEE/8'hFE/8'h00/8'hFF (BAT/ack/echo/resend/error): ignored; flags kept.
//   other      : ps2_key <= {~ps2_key[10], ~rel, ext, sr}; ext<=0, rel<=0.
//  frame_err also clears ext and rel (partial prefix sequence discarded); skip unchanged.
//  ps2_key holds its value between events; exactly one toggle flip per emitted event.
//  Simultaneous fall and timeout terminal count: fall wins (frame continues).
//  busy = (state != IDLE), registered with state.
// TESTING
//  Frame 0x1C, parity 0, stop 1, 12 kHz bit rate from reset -> ps2_key=11'h61C, frame_err never high.
//  Then F0,1C -> one update only, ps2_key=11'h01C (toggle 0, pressed 0).
//  E0,75 then E0,F0,75 -> 11'h775 then 11'h175; exactly two toggles total.
//  0x1C with parity 1 -> frame_err 1-cycle pulse at stop fall, ps2_key unchanged; next good 0x1C -> 11'h61C.
//  5 data bits then lines idle high -> frame_err exactly TIMEOUT cycles after last fall, busy=0; good 0x29 next -> 11'h629.
//  Glitch: 3-cycle low pulse on ps2_clk (< FILTER_LEN) in IDLE -> no state change; reset asserted mid-DATA -> busy=0 next cycle, no event.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the raw lines, deserializes
// device->host frames and folds E0/F0/E1 prefixes into one 11-bit key event word.
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 12000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Index 0 carries the PS/2 clock line, index 1 the data line.
    logic [1:0]     sync1;
    logic [1:0]     sync2;
    logic [1:0]     filt;
    logic [FCW-1:0] fcnt [2];
    logic           clk_filt_d;

    state_t         state;
    state_t         state_d;
    logic [2:0]     bit_cnt;
    logic [7:0]     sr;
    logic           par;
    logic [TCW-1:0] idle_cnt;
    logic           ext;
    logic           rel;
    logic [2:0]     skip;

    logic           fall_c;
    logic           data_c;
    logic           timeout_c;
    logic           shift_c;
    logic           latch_p_c;
    logic           byte_ok_c;
    logic           err_c;

    // Synchronizer and counter filter; a level is accepted only after it holds FILTER_LEN cycles.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            filt       <= 2'b11;
            clk_filt_d <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1      <= {ps2_data, ps2_clk};
            sync2      <= sync1;
            clk_filt_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FCW'(1);
                end
            end
        end
    end

    assign fall_c    = clk_filt_d & ~filt[0];
    assign data_c    = filt[1];
    // A fall on the terminal-count cycle keeps the frame alive.
    assign timeout_c = (state != IDLE) && !fall_c && (idle_cnt >= TCW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state;
        shift_c   = 1'b0;
        latch_p_c = 1'b0;
        byte_ok_c = 1'b0;
        err_c     = 1'b0;
        case (state)
            IDLE: begin
                if (fall_c) begin
                    if (!data_c) state_d = DATA;
                    else         err_c   = 1'b1;
                end
            end
            DATA: begin
                if (fall_c) begin
                    shift_c = 1'b1;
                    if (bit_cnt == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall_c) begin
                    latch_p_c = 1'b1;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (fall_c) begin
                    if (data_c && (^{sr, par})) byte_ok_c = 1'b1;
                    else                        err_c     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout_c) begin
            err_c   = 1'b1;
            state_d = IDLE;
        end
    end

    // Frame state, shift register and saturating inter-edge counter.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            sr       <= '0;
            par      <= 1'b0;
            idle_cnt <= '0;
        end else begin
            state <= state_d;
            busy  <= (state_d != IDLE);
            if (state == IDLE)  bit_cnt <= '0;
            else if (shift_c)   bit_cnt <= bit_cnt + 3'd1;
            if (shift_c)   sr  <= {data_c, sr[7:1]};
            if (latch_p_c) par <= data_c;
            if (state == IDLE || fall_c)           idle_cnt <= '0;
            else if (idle_cnt < TCW'(TIMEOUT))     idle_cnt <= idle_cnt + TCW'(1);
        end
    end

    // Prefix folding and event generation.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ps2_key   <= '0;
            frame_err <= 1'b0;
            ext       <= 1'b0;
            rel       <= 1'b0;
            skip      <= '0;
        end else begin
            frame_err <= err_c;
            if (err_c) begin
                ext <= 1'b0;
                rel <= 1'b0;
            end else if (byte_ok_c) begin
                if (skip != 3'd0) begin
                    skip <= skip - 3'd1;
                end else begin
                    case (sr)
                        8'hE1: begin
                            skip <= 3'd7;
                            ext  <= 1'b0;
                            rel  <= 1'b0;
                        end
                        8'hE0: ext <= 1'b1;
                        8'hF0: rel <= 1'b1;
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                        default: begin
                            ps2_key <= {~ps2_key[10], ~rel, ext, sr};
                            ext     <= 1'b0;
                            rel     <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames bit by bit and checks
// key words, error pulses, latencies, timeout, glitch filtering and reset.
module tb_ps2_key_decoder;

    localparam int FILTER_C  = 8;
    localparam int TIMEOUT_C = 400;
    localparam int HALF      = 50;
    // Raw clock fall to registered output: 2 sync + 8 filter + 1 output register.
    localparam int LAT       = 11;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   toggles  = 0;
    int   err_cnt  = 0;
    logic t_prev   = 1'b0;

    ps2_key_decoder #(.FILTER_LEN(FILTER_C), .TIMEOUT(TIMEOUT_C)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (frame_err === 1'b1) err_cnt++;
        if (ps2_key[10] !== t_prev) toggles++;
        t_prev = ps2_key[10];
    end

    // Sends the first nbits of an LSB-first frame; optionally returns with the clock held low.
    task automatic drive_frame(input logic [10:0] fr, input int nbits, input bit hold_low,
                               output int key_at, output int err_at);
        logic [10:0] key0;
        key_at = -1;
        err_at = -1;
        key0   = ps2_key;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (HALF) @(negedge clk_sys);
            ps2_clk = 1'b0;
            if (i == nbits - 1 && hold_low) return;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk_sys);
                if (i == nbits - 1) begin
                    if (key_at < 0 && ps2_key !== key0) key_at = k;
                    if (err_at < 0 && frame_err === 1'b1) err_at = k;
                end
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par,
                             output int key_at, output int err_at);
        logic p;
        p = ~(^b) ^ bad_par;
        drive_frame({1'b1, p, b, 1'b0}, 11, 1'b0, key_at, err_at);
        repeat (HALF) @(negedge clk_sys);
    endtask

    task automatic test_reset;
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (3) @(negedge clk_sys);
        n_checks++; if (ps2_key !== 11'h000) begin n_fail++; $display("FAIL reset_key: got %h expected %h", ps2_key, 11'h000); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        repeat (5) @(negedge clk_sys);
    endtask

    task automatic test_make;
        int ka, ea, e0, t0;
        e0 = err_cnt; t0 = toggles;
        send_byte(8'h1C, 1'b0, ka, ea);
        n_checks++; if (ps2_key !== 11'h61C) begin n_fail++; $display("FAIL make_key: got %h expected %h", ps2_key, 11'h61C); end
        n_checks++; if (ka !== LAT) begin n_fail++; $display("FAIL make_latency: got %0d expected %0d", ka, LAT); end
        n_checks++; if (err_cnt !== e0) begin n_fail++; $display("FAIL make_no_err: got %0d expected %0d", err_cnt, e0); end
        n_checks++; if (toggles !== t0 + 1) begin n_fail++; $display("FAIL make_toggles: got %0d expected %0d", toggles, t0 + 1); end
    endtask

    task automatic test_break;
        int ka, ea, t0;
        t0 = toggles;
        send_byte(8'hF0, 1'b0, ka, ea);
        n_checks++; if (ka !== -1 || ps2_key !== 11'h61C) begin n_fail++; $display("FAIL break_prefix: got %h at %0d expected %h unchanged", ps2_key, ka, 11'h61C); end
        send_byte(8'h1C, 1'b0, ka, ea);
        n_checks++; if (ps2_key !== 11'h01C) begin n_fail++; $display("FAIL break_key: got %h expected %h", ps2_key, 11'h01C); end
        n_checks++; if (toggles !== t0 + 1) begin n_fail++; $display("FAIL break_toggles: got %0d expected %0d", toggles, t0 + 1); end
    endtask

    task automatic test_extended;
        int ka, ea, t0;
        t0 = toggles;
        send_byte(8'hE0, 1'b0, ka, ea);
        n_checks++; if (ka !== -1) begin n_fail++; $display("FAIL ext_prefix: key changed at %0d expected no change", ka); end
        send_byte(8'h75, 1'b0, ka, ea);
        n_checks++; if (ps2_key !== 11'h775) begin n_fail++; $display("FAIL ext_make: got %h expected %h", ps2_key, 11'h775); end
        send_byte(8'hE0, 1'b0, ka, ea);
        send_byte(8'hF0, 1'b0, ka, ea);
        n_checks++; if (ps2_key !== 11'h775) begin n_fail++; $display("FAIL ext_break_prefix: got %h expected %h", ps2_key, 11'h775); end
        send_byte(8'h75, 1'b0, ka, ea);
        n_checks++; if (ps2_key !== 11'h175) begin n_fail++; $display("FAIL ext_break: got %h expected %h", ps2_key, 11'h175); end
        n_checks++; if (toggles !== t0 + 2) begin n_fail++; $display("FAIL ext_toggles: got %0d expected %0d", toggles, t0 + 2); end
    endtask

    task automatic test_parity_err;
        int ka, ea, e0;
        e0 = err_cnt;
        send_byte(8'h1C, 1'b1, ka, ea);
        n_checks++; if (ea !== LAT) begin n_fail++; $display("FAIL parity_err_time: got %0d expected %0d", ea, LAT); end
        n_checks++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL parity_err_width: got %0d cycles expected 1", err_cnt - e0); end
        n_checks++; if (ps2_key !== 11'h175) begin n_fail++; $display("FAIL parity_key_hold: got %h expected %h", ps2_key, 11'h175); end
        send_byte(8'h1C, 1'b0, ka, ea);
        n_checks++; if (ps2_key !== 11'h61C) begin n_fail++; $display("FAIL parity_recover: got %h expected %h", ps2_key, 11'h61C); end
    endtask

    task automatic test_timeout;
        int ka, ea, e0, err_at;
        logic busy_pre, busy_at;
        @(negedge clk_sys); reset = 1'b1;
        repeat (2) @(negedge clk_sys); reset = 1'b0;
        repeat (5) @(negedge clk_sys);
        e0 = err_cnt; err_at = -1; busy_pre = 1'bx; busy_at = 1'bx;
        drive_frame({1'b1, 1'b0, 8'h1C, 1'b0}, 6, 1'b1, ka, ea);
        for (int k = 1; k <= TIMEOUT_C + 40; k++) begin
            @(negedge clk_sys);
            if (k == HALF) begin ps2_clk = 1'b1; ps2_data = 1'b1; end
            if (k == TIMEOUT_C + LAT - 1) busy_pre = busy;
            if (err_at < 0 && frame_err === 1'b1) begin err_at = k; busy_at = busy; end
        end
        n_checks++; if (err_at !== TIMEOUT_C + LAT) begin n_fail++; $display("FAIL timeout_time: got %0d expected %0d", err_at, TIMEOUT_C + LAT); end
        n_checks++; if (busy_pre !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_before: got %b expected 1", busy_pre); end
        n_checks++; if (busy_at !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_after: got %b expected 0", busy_at); end
        n_checks++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL timeout_err_width: got %0d cycles expected 1", err_cnt - e0); end
        send_byte(8'h29, 1'b0, ka, ea);
        n_checks++; if (ps2_key !== 11'h629) begin n_fail++; $display("FAIL timeout_recover: got %h expected %h", ps2_key, 11'h629); end
    endtask

    task automatic test_pause_skip;
        int ka, ea, t0, changed;
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        t0 = toggles; changed = 0;
        for (int i = 0; i < 8; i++) begin
            send_byte(seq[i], 1'b0, ka, ea);
            if (ka != -1) changed++;
        end
        n_checks++; if (changed !== 0 || ps2_key !== 11'h629) begin n_fail++; $display("FAIL pause_swallow: got %h with %0d updates expected %h with 0", ps2_key, changed, 11'h629); end
        n_checks++; if (toggles !== t0) begin n_fail++; $display("FAIL pause_toggles: got %0d expected %0d", toggles, t0); end
        send_byte(8'hE0, 1'b0, ka, ea);
        send_byte(8'hAA, 1'b0, ka, ea);
        n_checks++; if (ka !== -1) begin n_fail++; $display("FAIL bat_ignored: key changed at %0d expected no change", ka); end
        send_byte(8'h75, 1'b0, ka, ea);
        n_checks++; if (ps2_key !== 11'h375) begin n_fail++; $display("FAIL bat_keeps_ext: got %h expected %h", ps2_key, 11'h375); end
        send_byte(8'hE0, 1'b0, ka, ea);
        send_byte(8'h1C, 1'b1, ka, ea);
        send_byte(8'h1C, 1'b0, ka, ea);
        n_checks++; if (ps2_key !== 11'h61C) begin n_fail++; $display("FAIL err_clears_ext: got %h expected %h", ps2_key, 11'h61C); end
    endtask

    task automatic test_glitch;
        int e0, busy_seen, err_at;
        logic [10:0] key0;
        int widths [2];
        widths = '{3, FILTER_C - 1};
        key0 = ps2_key; e0 = err_cnt; busy_seen = 0;
        foreach (widths[w]) begin
            @(negedge clk_sys); ps2_clk = 1'b0;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk_sys);
                if (k == widths[w]) ps2_clk = 1'b1;
                if (busy === 1'b1) busy_seen++;
            end
        end
        n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL glitch_busy: got %0d busy cycles expected 0", busy_seen); end
        n_checks++; if (err_cnt !== e0 || ps2_key !== key0) begin n_fail++; $display("FAIL glitch_quiet: got key %h err %0d expected %h 0", ps2_key, err_cnt - e0, key0); end
        // A full-length low pulse with data high is accepted as a fall and a bad start bit.
        err_at = -1;
        @(negedge clk_sys); ps2_clk = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_sys);
            if (k == FILTER_C) ps2_clk = 1'b1;
            if (busy === 1'b1) busy_seen++;
            if (err_at < 0 && frame_err === 1'b1) err_at = k;
        end
        n_checks++; if (err_at !== LAT) begin n_fail++; $display("FAIL bad_start_err: got %0d expected %0d", err_at, LAT); end
        n_checks++; if (busy_seen !== 0 || ps2_key !== key0) begin n_fail++; $display("FAIL bad_start_idle: got busy %0d key %h expected 0 %h", busy_seen, ps2_key, key0); end
        repeat (HALF) @(negedge clk_sys);
    endtask

    task automatic test_reset_mid_frame;
        int ka, ea, e0;
        drive_frame({1'b1, 1'b0, 8'h1C, 1'b0}, 4, 1'b0, ka, ea);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy: got %b expected 1", busy); end
        reset = 1'b1;
        @(negedge clk_sys);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
        n_checks++; if (ps2_key !== 11'h000) begin n_fail++; $display("FAIL reset_mid_key: got %h expected %h", ps2_key, 11'h000); end
        reset = 1'b0; ps2_data = 1'b1; e0 = err_cnt;
        repeat (4 * HALF) @(negedge clk_sys);
        n_checks++; if (busy !== 1'b0 || err_cnt !== e0 || ps2_key !== 11'h000) begin n_fail++; $display("FAIL reset_mid_quiet: got busy %b err %0d key %h expected 0 0 000", busy, err_cnt - e0, ps2_key); end
        send_byte(8'h1C, 1'b0, ka, ea);
        n_checks++; if (ps2_key !== 11'h61C || ka !== LAT) begin n_fail++; $display("FAIL reset_mid_recover: got %h at %0d expected %h at %0d", ps2_key, ka, 11'h61C, LAT); end
    endtask

    initial begin
        ps2_clk = 1'b1; ps2_data = 1'b1; reset = 1'b1;
        test_reset;
        test_make;
        test_break;
        test_extended;
        test_parity_err;
        test_timeout;
        test_pause_skip;
        test_glitch;
        test_reset_mid_frame;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
